// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write byte-enabled register file with write-first bypass
// Reads sample the post-clear/post-write next state, so bypass falls out of the storage next-state logic.
module regfile_2r1w #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [WIDTH-1:0]  rd0_data,
    output logic [WIDTH-1:0]  rd1_data,
    output logic              rd0_valid,
    output logic              rd1_valid
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = WIDTH / 8;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] wr_merged;
    logic             wr_live;
    logic [WIDTH-1:0] rd0_data_q, rd0_data_d;
    logic [WIDTH-1:0] rd1_data_q, rd1_data_d;
    logic             rd0_valid_q, rd1_valid_q;

    always_comb begin
        wr_merged = regs_q[wr_addr];
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        wr_live = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    end

    // Priority clr > write; register 0 stays zero under ZERO_REG because it is never written.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = clr ? '0 : regs_q[i];
        end
        if (!clr && wr_live) begin
            regs_d[wr_addr] = wr_merged;
        end
    end

    always_comb begin
        rd0_data_d = rd0_en ? regs_d[rd0_addr] : rd0_data_q;
        rd1_data_d = rd1_en ? regs_d[rd1_addr] : rd1_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd0_data_q  <= '0;
            rd1_data_q  <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd0_data_q  <= rd0_data_d;
            rd1_data_q  <= rd1_data_d;
            rd0_valid_q <= rd0_en;
            rd1_valid_q <= rd1_en;
        end
    end

    assign rd0_data  = rd0_data_q;
    assign rd1_data  = rd1_data_q;
    assign rd0_valid = rd0_valid_q;
    assign rd1_valid = rd1_valid_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed table-driven bench for regfile_2r1w (WIDTH=16, ADDR_W=3)
module tb_regfile_2r1w;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [1:0]  wr_be = '0;
    logic [15:0] wr_data = '0;
    logic        rd0_en = 1'b0, rd1_en = 1'b0;
    logic [2:0]  rd0_addr = '0, rd1_addr = '0;
    logic [15:0] rd0_data, rd1_data, z_rd0_data, z_rd1_data;
    logic        rd0_valid, rd1_valid, z_rd0_valid, z_rd1_valid;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd0_en(rd0_en), .rd0_addr(rd0_addr),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd0_data(rd0_data), .rd1_data(rd1_data),
        .rd0_valid(rd0_valid), .rd1_valid(rd1_valid)
    );

    regfile_2r1w #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd0_en(rd0_en), .rd0_addr(rd0_addr),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd0_data(z_rd0_data), .rd1_data(z_rd1_data),
        .rd0_valid(z_rd0_valid), .rd1_valid(z_rd1_valid)
    );

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [1:0]  be;
        logic [15:0] wd;
        logic        clr;
        logic        r0_en;
        logic [2:0]  r0_a;
        logic        r1_en;
        logic [2:0]  r1_a;
        logic        e0_v;
        logic [15:0] e0_d;
        logic        e1_v;
        logic [15:0] e1_d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [2:0] wa, logic [1:0] be, logic [15:0] wd,
                                logic c, logic r0e, logic [2:0] r0a, logic r1e, logic [2:0] r1a,
                                logic e0v, logic [15:0] e0d, logic e1v, logic [15:0] e1d);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.be = be; v.wd = wd; v.clr = c;
        v.r0_en = r0e; v.r0_a = r0a; v.r1_en = r1e; v.r1_a = r1a;
        v.e0_v = e0v; v.e0_d = e0d; v.e1_v = e1v; v.e1_d = e1d;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(vec_t v);
        wr_en = v.wr_en; wr_addr = v.wr_addr; wr_be = v.be; wr_data = v.wd; clr = v.clr;
        rd0_en = v.r0_en; rd0_addr = v.r0_a; rd1_en = v.r1_en; rd1_addr = v.r1_a;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        vecs.push_back(mk(0, 0, 2'b00, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 2'b00, 16'h0, 0, 1, 3'(i), 1, 3'(7 - i), 1, 16'h0, 1, 16'h0));
        vecs.push_back(mk(1, 5, 2'b11, 16'hBEEF, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 2'b00, 16'h0000, 0, 1, 5, 1, 5, 1, 16'hBEEF, 1, 16'hBEEF));
        vecs.push_back(mk(1, 2, 2'b11, 16'h1234, 0, 0, 0, 0, 0, 0, 16'hBEEF, 0, 16'hBEEF));
        vecs.push_back(mk(1, 2, 2'b10, 16'hAB00, 0, 1, 5, 1, 2, 1, 16'hBEEF, 1, 16'hAB34));
        vecs.push_back(mk(0, 0, 2'b00, 16'h0000, 0, 1, 2, 0, 0, 1, 16'hAB34, 0, 16'hAB34));
        vecs.push_back(mk(1, 3, 2'b01, 16'h77CC, 0, 1, 3, 0, 0, 1, 16'h00CC, 0, 16'hAB34));
        vecs.push_back(mk(1, 3, 2'b00, 16'hFFFF, 0, 0, 0, 1, 3, 0, 16'h00CC, 1, 16'h00CC));
        vecs.push_back(mk(1, 1, 2'b11, 16'hFFFF, 1, 1, 1, 1, 5, 1, 16'h0000, 1, 16'h0000));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 2'b00, 16'h0, 0, 1, 3'(i), 1, 3'(i), 1, 16'h0, 1, 16'h0));
        vecs.push_back(mk(1, 1, 2'b11, 16'h1111, 0, 1, 1, 0, 0, 1, 16'h1111, 0, 16'h0000));

        idle();
        #23 rst = 1'b0;
        #1;
        chk("reset rd0_valid", 32'(rd0_valid), 0);
        chk("reset rd1_valid", 32'(rd1_valid), 0);
        chk("reset rd0_data", 32'(rd0_data), 0);
        chk("reset rd1_data", 32'(rd1_data), 0);
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            drive(vecs[k]);
            @(posedge clk); #1;
            chk($sformatf("v%0d rd0_valid", k), 32'(rd0_valid), 32'(vecs[k].e0_v));
            chk($sformatf("v%0d rd0_data", k), 32'(rd0_data), 32'(vecs[k].e0_d));
            chk($sformatf("v%0d rd1_valid", k), 32'(rd1_valid), 32'(vecs[k].e1_v));
            chk($sformatf("v%0d rd1_data", k), 32'(rd1_data), 32'(vecs[k].e1_d));
            chk($sformatf("v%0d z rd0_data", k), 32'(z_rd0_data), 32'(vecs[k].e0_d));
            chk($sformatf("v%0d z rd1_data", k), 32'(z_rd1_data), 32'(vecs[k].e1_d));
        end

        // Write to address 0 with same-cycle reads: bypass on the plain file, zero on ZERO_REG.
        drive(mk(1, 0, 2'b11, 16'h5A5A, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("zero bypass plain rd0", 32'(rd0_data), 32'h5A5A);
        chk("zero bypass plain rd1", 32'(rd1_data), 32'h5A5A);
        chk("zero bypass z rd0", 32'(z_rd0_data), 32'h0000);
        chk("zero bypass z rd1", 32'(z_rd1_data), 32'h0000);
        chk("zero bypass z rd0_valid", 32'(z_rd0_valid), 1);
        drive(mk(0, 0, 2'b00, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("zero later plain rd0", 32'(rd0_data), 32'h5A5A);
        chk("zero later z rd0", 32'(z_rd0_data), 32'h0000);
        chk("zero later z rd0_valid", 32'(z_rd0_valid), 1);

        // Reset in the middle of a read's valid cycle.
        drive(mk(1, 4, 2'b11, 16'h00C3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(0, 0, 2'b00, 16'h0, 0, 1, 4, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("pre-rst rd0_valid", 32'(rd0_valid), 1);
        chk("pre-rst rd0_data", 32'(rd0_data), 32'h00C3);
        #2 rst = 1'b1;
        #1;
        chk("async rst rd0_valid", 32'(rd0_valid), 0);
        chk("async rst rd0_data", 32'(rd0_data), 0);
        chk("async rst rd1_data", 32'(rd1_data), 0);
        @(posedge clk); #1;
        chk("held rst rd0_valid", 32'(rd0_valid), 0);
        chk("held rst rd0_data", 32'(rd0_data), 0);
        rst = 1'b0;
        drive(mk(0, 0, 2'b00, 16'h0, 0, 1, 4, 1, 2, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("post-rst rd0_valid", 32'(rd0_valid), 1);
        chk("post-rst rd0_data", 32'(rd0_data), 0);
        chk("post-rst rd1_data", 32'(rd1_data), 0);
        idle();
        @(posedge clk); #1;
        chk("idle rd0_valid", 32'(rd0_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file with two independent registered read ports and one byte-enabled write port. It is the next generation of the team's 4x8 single-read register file, generalised in width and depth. It adds write-to-read bypass, an optional hardwired-zero register 0, and a synchronous clear-all. It sits beside datapath ALUs that need two operands per cycle.

## Interface
- `WIDTH`, default 8: data width in bits; must be a multiple of 8.
- `ADDR_W`, default 2: address width; depth is 2**ADDR_W.
- `ZERO_REG`, default 0: when 1, register 0 always reads 0 and writes to it are discarded.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: reset; asynchronous, active-high.
- `clr` input, 1: synchronous clear of all registers.
- `wr_en` input, 1: write strobe.
- `wr_addr` input, ADDR_W: write address.
- `wr_be` input, WIDTH/8: byte enables; bit i covers data bits [8i+7:8i].
- `wr_data` input, WIDTH: write data.
- `rd0_en`, `rd1_en` input, 1: read requests.
- `rd0_addr`, `rd1_addr` input, ADDR_W: read addresses.
- `rd0_data`, `rd1_data` output, WIDTH: registered read data.
- `rd0_valid`, `rd1_valid` output, 1: read data valid, pulsed one cycle.

## Operation
**Storage:** 2**ADDR_W words of WIDTH bits.

**Write:**
- On a clock edge with `wr_en` high and `clr` low, the bytes of `regs[wr_addr]` with `wr_be[i]`=1 take `wr_data`.
- Other bytes hold their value.
- `wr_be`=0 with `wr_en`=1 is a legal no-op.

**Clear:**
- `clr` high zeroes every register on that edge.
- `clr` overrides a write in the same cycle; the write is lost.

**Reads:**
- Each port is independent. Both ports may read the same address.
- When `rdN_en` is high at edge N, `rdN_data` is loaded and `rdN_valid`=1 for the cycle after edge N.
- When `rdN_en` is low, `rdN_valid`=0 and `rdN_data` holds its last value.

**Bypass (write-first):**
- A read in the same cycle as a write to the same address returns the merged word: new bytes where `wr_be` is set, old bytes elsewhere.
- A read in the same cycle as `clr` returns 0.

**ZERO_REG=1:**
- A read of address 0 always returns 0, including under bypass.
- A write to address 0 has no effect.

**Addresses:** always in range by construction (full power-of-two depth), so there is no out-of-range case.

## Timing
- **Read latency:** 1 cycle, fixed. Throughput is one read per port per cycle plus one write per cycle, with no stalls.
- **Write visibility:** written data is visible to a read issued in the same cycle through bypass. It is visible from storage in every later cycle.
- **Reset values:** all registers 0; `rd0_data`=`rd1_data`=0; `rd0_valid`=`rd1_valid`=0.
- **Reset mid-operation:**
  - Asserting `rst` clears storage and outputs immediately.
  - An in-flight read's valid is dropped.
  - The first edge after deassertion behaves normally.
- **Priority per edge:** `rst` > `clr` > write. Reads are evaluated against the post-priority next-state value.

## Test plan
1. **Reset:** assert `rst`, then release. Read every address on both ports → each read returns 0 one cycle later with valid=1; valid is 0 before any read is issued.
2. **Basic write/read:** WIDTH=16, ADDR_W=3. Write 0xBEEF to address 5 with be=2'b11. Next cycle read port 0 at address 5 and port 1 at address 5 → both return 0xBEEF with valid one cycle later.
3. **Partial write and bypass:**
   - Address 2 holds 0x1234.
   - In a single cycle, write 0xAB00 with be=2'b10 and read address 2 on port 1.
   - Required: port 1 returns 0xAB34 on the next cycle, and storage holds 0xAB34.
4. **Clear vs write:**
   - Registers hold nonzero values.
   - In the same cycle assert `clr`, `wr_en` (address 1, 0xFFFF) and a read of address 1.
   - Required: the read returns 0, and all addresses read 0 afterwards.
5. **ZERO_REG=1:** write 0x5A5A to address 0 while reading address 0 on both ports → both return 0; a later read of address 0 also returns 0.
6. **Reset mid-read:** issue a read of an address holding 0x00C3, then assert `rst` asynchronously before the next edge → `rd0_valid` is 0 and `rd0_data` is 0 at once, and the data never appears.
